dm_mmio_txfifo: RTL and testbench
=================================

# dm_mmio_txfifo

Memory-mapped responder on the RISC_V data-memory bus, the target end of the core's `MEM_READ`/`MEM_WRITE`/`DM_addr` interface. It claims one 16-byte address window, queues words stored by the core into a TX FIFO, and exposes that FIFO to a host, bench or peripheral through a valid/ready stream. The system top muxes `DATA_OUT` against data_memory using `HIT`. It is the store-side counterpart to data_memory for program-to-host output.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: window base; bits [3:0] must be 0.
- `DEPTH`, default 8: FIFO entries; power of 2, range 2..128.
- `CLK`  in  1: single clock; all logic is on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `MEM_READ`  in  1: core load strobe, sampled every cycle.
- `MEM_WRITE`  in  1: core store strobe, sampled every cycle.
- `ADDR`  in  32: core data address.
- `WRITE_DATA`  in  32: core store data.
- `DATA_OUT`  out  32: registered load data.
- `HIT`  out  1: registered; 1 when the previous-cycle access fell in the window.
- `HOST_VALID`  out  1: FIFO not empty.
- `HOST_DATA`  out  32: FIFO head; 0 when empty.
- `HOST_READY`  in  1: host accepts the head.

## Operation
- Decode:
  - The window is selected when `ADDR[31:4] == BASE_ADDR[31:4]`.
  - The register is selected by `ADDR[3:2]`; `ADDR[1:0]` is ignored.
- Register map:
  - 0x0 TXDATA: a write pushes `WRITE_DATA`. If the FIFO is full, the word is dropped and DROPS increments. A read returns 0.
  - 0x4 STATUS: a read returns bit0 = empty, bit1 = full, bits[15:8] = count, zero-extended. Writes are ignored.
  - 0x8 DROPS: a read returns the 16-bit drop counter, zero-extended. The counter saturates at 16'hFFFF. Any write clears it to 0.
  - 0xC: reserved. Reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo `DEPTH`.
  - count width is log2(`DEPTH`)+1.
  - A pop happens when `HOST_VALID && HOST_READY`.
- Simultaneous push and pop:
  - When full: both take effect, count is unchanged, and nothing is dropped.
  - When empty: the push is accepted and no pop occurs.
  - Otherwise: count is unchanged and both pointers advance.
- A DROPS clear and a drop in the same cycle: the clear wins and the counter is 0.
- `MEM_READ` and `MEM_WRITE` together: both take effect. The read returns the pre-edge state.
- Out-of-window access: no state changes, and `DATA_OUT` and `HIT` are 0 on the next cycle.

## Timing
- Reset values:
  - `DATA_OUT` = 0, `HIT` = 0.
  - `HOST_VALID` = 0, `HOST_DATA` = 0.
  - count = 0, both pointers = 0, DROPS = 0.
  - Reset overrides a push or pop in the same cycle. A mid-stream reset discards queued words.
- Load latency is 1 cycle. `DATA_OUT`/`HIT` update at the edge after `MEM_READ` is sampled and hold until the next edge. They are 0 after a cycle with no in-window read.
- A STATUS or DROPS read returns the value from before any same-cycle push, pop or clear.
- A push at edge N makes `HOST_VALID` = 1 and the head visible after edge N, so the FIFO has 1-cycle fall-through.
- A pop at edge N presents the next head, or `HOST_VALID` = 0, after edge N.
- `HOST_DATA` is stable while `HOST_VALID && !HOST_READY`.
- Throughput is 1 push and 1 pop per cycle.

## Test plan
- Basic push and drain:
  - Stimulus: store 0xA, 0xB, 0xC to BASE+0 with `HOST_READY` = 0, then raise `HOST_READY`.
  - Required: STATUS reads count = 3. `HOST_DATA` shows 0xA, 0xB, 0xC on consecutive cycles, then `HOST_VALID` = 0 and STATUS = 0x1.
- Overflow and DROPS clear:
  - Stimulus: with `HOST_READY` = 0, do 10 stores (DEPTH=8), then read DROPS, then write BASE+8 and read DROPS again.
  - Required: STATUS = 0x0802, the first DROPS read returns 2, the second returns 0, and the FIFO holds words 1..8 in order.
- Full with simultaneous push and pop:
  - Stimulus: with the FIFO full and `HOST_READY` = 1, store 0x55.
  - Required: count stays 8, DROPS stays 0, and 0x55 leaves last.
- Load timing and decode:
  - Stimulus: read BASE+4 while a push occurs in the same cycle.
  - Required: `DATA_OUT` = pre-push STATUS one cycle later with `HIT` = 1.
  - Stimulus: read BASE+0x10 and BASE+0xC.
  - Required: `DATA_OUT` = 0, with `HIT` = 0 for BASE+0x10 and `HIT` = 1 for BASE+0xC.
- Wrap-around:
  - Stimulus: 20 pushes interleaved with pops, with `HOST_READY` toggling pseudo-randomly.
  - Required: the output sequence matches input order, no drops, and `HOST_DATA` holds while stalled.
- Reset mid-operation:
  - Stimulus: assert `RST` for 1 cycle with 5 words queued and a push in flight.
  - Required: after reset, `HOST_VALID` = 0, STATUS = 0x1, DROPS = 0, `DATA_OUT` = 0, and the next store becomes the head.

Source files
------------

// File: rtl/dm_mmio_txfifo.sv
// rtl/dm_mmio_txfifo.sv - MMIO TX FIFO responder on the data-memory bus with a host valid/ready stream
module dm_mmio_txfifo #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] DATA_OUT,
    output logic        HIT,
    output logic        HOST_VALID,
    output logic [31:0] HOST_DATA,
    input  logic        HOST_READY
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DROPS  = 2'd2;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   drops;

    logic          in_win;
    logic [1:0]    reg_sel;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          drops_clr;
    logic [31:0]   rd_data;
    logic          unused_addr_bits;

    // Byte offset within a word carries no meaning for this window
    assign unused_addr_bits = ^ADDR[1:0];

    assign in_win    = (ADDR[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = ADDR[3:2];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = !empty && HOST_READY;
    assign push_req  = MEM_WRITE && in_win && (reg_sel == REG_TXDATA);
    // A full FIFO still accepts a store when the host drains the head in the same cycle
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign drops_clr = MEM_WRITE && in_win && (reg_sel == REG_DROPS);

    assign HOST_VALID = !empty;
    assign HOST_DATA  = empty ? 32'h0 : mem[rd_ptr];

    // Register read mux built from pre-edge state so loads see values before same-cycle updates
    always_comb begin
        rd_data = 32'h0;
        case (reg_sel)
            REG_STATUS: rd_data = {16'h0, 8'(count), 6'h0, full, empty};
            REG_DROPS:  rd_data = {16'h0, drops};
            default:    rd_data = 32'h0;
        endcase
    end

    // FIFO storage; pointers are reset, contents need not be
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= WRITE_DATA;
        end
    end

    // Pointers, occupancy, drop counter and registered load response
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drops    <= 16'h0;
            DATA_OUT <= 32'h0;
            HIT      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drops_clr) begin
                drops <= 16'h0;
            end else if (drop && (drops != 16'hFFFF)) begin
                drops <= drops + 16'h1;
            end
            DATA_OUT <= (MEM_READ && in_win) ? rd_data : 32'h0;
            HIT      <= MEM_READ && in_win;
        end
    end
endmodule

// File: tb/tb_dm_mmio_txfifo.sv
// tb/tb_dm_mmio_txfifo.sv - self-checking bench for dm_mmio_txfifo with a queue scoreboard
module tb_dm_mmio_txfifo;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] data_out;
    logic        hit;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [15:0] m_drops = 16'h0;
    logic        r;

    dm_mmio_txfifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .CLK(clk),
        .RST(rst),
        .MEM_READ(mem_read),
        .MEM_WRITE(mem_write),
        .ADDR(addr),
        .WRITE_DATA(write_data),
        .DATA_OUT(data_out),
        .HIT(hit),
        .HOST_VALID(host_valid),
        .HOST_DATA(host_data),
        .HOST_READY(host_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [7:0] cnt;
        cnt = 8'(q.size());
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1:    return {16'h0, cnt, 6'h0, (q.size() == DEPTH), (q.size() == 0)};
            2'd2:    return {16'h0, m_drops};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check stream against the model, clock, update model, check load response
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy);
        logic [31:0] exp_do;
        logic        exp_hit;
        logic        win;
        logic        pop;
        logic        full;
        logic        push;
        logic        clr;
        mem_read   = rd;
        mem_write  = wr;
        addr       = a;
        write_data = wd;
        host_ready = rdy;
        #1;
        chk("host_valid", {31'h0, host_valid}, {31'h0, (q.size() != 0)});
        chk("host_data", host_data, (q.size() != 0) ? q[0] : 32'h0);
        win     = (a[31:4] == BASE[31:4]);
        exp_hit = rd && win && !rst;
        exp_do  = (rd && !rst) ? model_rd(a) : 32'h0;
        pop     = (q.size() != 0) && rdy;
        full    = (q.size() == DEPTH);
        push    = wr && win && (a[3:2] == 2'd0);
        clr     = wr && win && (a[3:2] == 2'd2);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_drops = 16'h0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push && (!full || pop)) q.push_back(wd);
            if (clr) m_drops = 16'h0;
            else if (push && full && !pop && m_drops != 16'hFFFF) m_drops = m_drops + 16'h1;
        end
        chk("data_out", data_out, exp_do);
        chk("hit", {31'h0, hit}, {31'h0, exp_hit});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 0);
        rst = 1'b0;
        chk("rst_valid", {31'h0, host_valid}, 32'h0);
        chk("rst_data", host_data, 32'h0);
        chk("rst_dout", data_out, 32'h0);

        // Basic push and drain
        step(0, 1, BASE, 32'hA, 0);
        step(0, 1, BASE, 32'hB, 0);
        step(0, 1, BASE, 32'hC, 0);
        step(1, 0, BASE + 32'h4, 32'h0, 0);
        chk("basic_status3", data_out, 32'h0000_0300);
        chk("basic_head", host_data, 32'hA);
        repeat (4) step(0, 0, 32'h0, 32'h0, 1);
        step(1, 0, BASE + 32'h4, 32'h0, 1);
        chk("basic_status_empty", data_out, 32'h1);

        // Overflow and DROPS clear
        for (int i = 1; i <= 10; i++) step(0, 1, BASE, 32'(i), 0);
        step(1, 0, BASE + 32'h4, 32'h0, 0);
        chk("ovf_status", data_out, 32'h0000_0802);
        step(1, 0, BASE + 32'h8, 32'h0, 0);
        chk("ovf_drops2", data_out, 32'h2);
        step(0, 1, BASE + 32'h8, 32'h0, 0);
        step(1, 0, BASE + 32'h8, 32'h0, 0);
        chk("ovf_drops_clr", data_out, 32'h0);
        chk("ovf_head", host_data, 32'h1);

        // Full with simultaneous push and pop
        step(0, 1, BASE, 32'h55, 1);
        step(1, 0, BASE + 32'h4, 32'h0, 0);
        chk("full_pp_status", data_out, 32'h0000_0802);
        step(1, 0, BASE + 32'h8, 32'h0, 0);
        chk("full_pp_drops", data_out, 32'h0);
        repeat (7) step(0, 0, 32'h0, 32'h0, 1);
        chk("full_pp_last", host_data, 32'h55);
        step(0, 0, 32'h0, 32'h0, 1);
        chk("full_pp_empty", {31'h0, host_valid}, 32'h0);

        // Load timing and decode
        step(0, 1, BASE, 32'h11, 0);
        step(0, 1, BASE, 32'h22, 0);
        step(1, 0, BASE + 32'h4, 32'h0, 1);
        chk("ld_status_pre_pop", data_out, 32'h0000_0200);
        step(1, 1, BASE, 32'h33, 0);
        chk("ld_txdata_rd", data_out, 32'h0);
        chk("ld_txdata_hit", {31'h0, hit}, 32'h1);
        step(1, 1, BASE + 32'h10, 32'h44, 0);
        chk("ld_oow_dout", data_out, 32'h0);
        chk("ld_oow_hit", {31'h0, hit}, 32'h0);
        step(1, 0, BASE + 32'hC, 32'h0, 0);
        chk("ld_rsvd_dout", data_out, 32'h0);
        chk("ld_rsvd_hit", {31'h0, hit}, 32'h1);
        step(0, 0, 32'h0, 32'h0, 0);
        chk("ld_idle_hit", {31'h0, hit}, 32'h0);
        repeat (3) step(0, 0, 32'h0, 32'h0, 1);

        // Wrap-around with a pseudo-random host
        for (int i = 0; i < 20; i++) begin
            r = (q.size() >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            step(0, 1, BASE, 32'h1000 + 32'(i), r);
            r = (q.size() >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            step(0, 0, 32'h0, 32'h0, r);
        end
        step(1, 0, BASE + 32'h8, 32'h0, 1);
        chk("wrap_drops", data_out, 32'h0);
        repeat (10) step(0, 0, 32'h0, 32'h0, 1);
        chk("wrap_empty", {31'h0, host_valid}, 32'h0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(0, 1, BASE, 32'h200 + 32'(i), 0);
        step(1, 0, BASE + 32'h4, 32'h0, 0);
        rst = 1'b1;
        step(1, 1, BASE, 32'h99, 0);
        rst = 1'b0;
        chk("mrst_valid", {31'h0, host_valid}, 32'h0);
        chk("mrst_dout", data_out, 32'h0);
        step(1, 0, BASE + 32'h4, 32'h0, 0);
        chk("mrst_status", data_out, 32'h1);
        step(1, 0, BASE + 32'h8, 32'h0, 0);
        chk("mrst_drops", data_out, 32'h0);
        step(0, 1, BASE, 32'h77, 0);
        chk("mrst_head", host_data, 32'h77);
        repeat (2) step(0, 0, 32'h0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
